pe_array_seq: RTL

- Sequencer for the X-by-Y systolic MAC array and its per-row output adders, for one C = A*B (+/- M) tile job.
- Latches a job (dataflow direction, inner length, adder mode) on a start handshake.
- Drives PE_mode, the column-skewed new_cal_en/new_cal_done strobes, operand read requests and the per-row M_adder_mode windows.
- Pulses done when the last row sum has left the adders; sits between the matrix control unit and the array instance.

---
 rtl/pe_array_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pe_array_seq.sv
// Sequencer for an X-by-Y systolic MAC array and its per-row output adders (one tile job).
// Optional perf counters (perf_cycles, perf_jobs) are built when PE_SEQ_PERF_EN is defined.
module pe_array_seq #(
    parameter int unsigned X       = 4,
    parameter int unsigned Y       = 4,
    parameter int unsigned L       = 4,
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned LW      = 8
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            start,
    output logic            ready,
    input  logic [1:0]      cfg_pe_mode,
    input  logic [LW-1:0]   cfg_len,
    input  logic [1:0]      cfg_m_mode,
    output logic [1:0]      PE_mode,
    output logic [Y-1:0]    new_cal_en,
    output logic [Y-1:0]    new_cal_done,
    output logic [2*X-1:0]  M_adder_mode,
    output logic            rd_en,
    output logic [LW-1:0]   rd_k,
    output logic            busy,
    output logic            done,
    output logic            err_len
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [15:0]     perf_cycles,
    output logic [15:0]     perf_jobs
`endif
);

    typedef enum logic [2:0] {StIdle, StLoad, StFeed, StDrain, StDone} state_e;

    // Y-2 may wrap when Y=1; modular addition with len_q still yields the right last index.
    localparam logic [LW-1:0] FeedOff   = LW'(Y - 2);
    localparam logic [LW-1:0] DrainLast = LW'(X + Y + ADD_LAT - 2);

    state_e          state_q, state_d;
    logic [LW-1:0]   fcnt_q, fcnt_d;
    logic [LW-1:0]   dcnt_q, dcnt_d;
    logic [LW-1:0]   len_q;
    logic [1:0]      pe_mode_q;
    logic [1:0]      mmode_q;
    logic            err_q;
    logic            accept;
    logic            len_ok;

    assign accept = start && (state_q == StIdle);
    assign len_ok = (cfg_len != '0) && (cfg_len <= LW'(L));

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q   <= StIdle;
            fcnt_q    <= '0;
            dcnt_q    <= '0;
            len_q     <= '0;
            pe_mode_q <= 2'b00;
            mmode_q   <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
            if (accept) begin
                len_q   <= cfg_len;
                mmode_q <= cfg_m_mode;
                err_q   <= !len_ok;
                // An error job never reaches LOAD, so the array keeps its previous dataflow.
                if (len_ok) pe_mode_q <= cfg_pe_mode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = len_ok ? StLoad : StDone;
            end
            StLoad: begin
                fcnt_d  = '0;
                state_d = StFeed;
            end
            StFeed: begin
                if (fcnt_q == len_q + FeedOff) begin
                    dcnt_d  = '0;
                    state_d = StDrain;
                end else begin
                    fcnt_d = fcnt_q + LW'(1);
                end
            end
            StDrain: begin
                if (dcnt_q == DrainLast) state_d = StDone;
                else                     dcnt_d  = dcnt_q + LW'(1);
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are pure decodes of registered state, so they move only on clock edges.
    always_comb begin
        ready        = (state_q == StIdle);
        busy         = (state_q == StLoad) || (state_q == StFeed) || (state_q == StDrain);
        done         = (state_q == StDone);
        err_len      = (state_q == StDone) && err_q;
        PE_mode      = pe_mode_q;
        rd_en        = (state_q == StFeed) && (fcnt_q < len_q);
        rd_k         = rd_en ? fcnt_q : '0;
        new_cal_en   = '0;
        new_cal_done = '0;
        M_adder_mode = '0;
        for (int j = 0; j < Y; j++) begin
            if (state_q == StFeed) begin
                new_cal_en[j]   = (fcnt_q >= LW'(j)) && (fcnt_q < LW'(j) + len_q);
                new_cal_done[j] = (fcnt_q == LW'(j) + len_q - LW'(1));
            end
        end
        for (int i = 0; i < X; i++) begin
            if ((state_q == StDrain) && (dcnt_q >= LW'(i)) && (dcnt_q <= LW'(i + Y - 1))) begin
                M_adder_mode[2*i +: 2] = mmode_q;
            end
        end
    end

`ifdef PE_SEQ_PERF_EN
    logic [15:0] cyc_q;
    logic [15:0] perf_cycles_q;
    logic [15:0] perf_jobs_q;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cyc_q         <= '0;
            perf_cycles_q <= '0;
            perf_jobs_q   <= '0;
        end else begin
            if (accept) begin
                cyc_q <= 16'd1;
            end else if (state_q != StIdle && state_q != StDone) begin
                cyc_q <= cyc_q + 16'd1;
            end
            if (state_q == StDone) begin
                perf_cycles_q <= cyc_q;
                if (perf_jobs_q != 16'hFFFF) perf_jobs_q <= perf_jobs_q + 16'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_jobs   = perf_jobs_q;
`endif

endmodule
